// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin DFF bank arbiter.
package dff_arb_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned MAX_NREQ  = 8;
  localparam int unsigned MAX_IDW   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One-hot decode of a requester index, sized for the largest supported bank.
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_IDW-1:0] idx);
    onehot = {{(MAX_NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  assign any = |req;

  // Scan farthest-to-nearest so the nearest requester after 'last' wins.
  always_comb begin
    winner = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) winner = IDW'((int'(last) + k) % NREQ);
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sequencing writes from NREQ requesters into one shared
// WIDTH-bit register, acking each completed write for one cycle.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = NREQ_DEF,
  parameter  int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  state_e           state, state_d;
  logic [NREQ-1:0]  gnt_d, ack_d;
  logic [IDW-1:0]   gnt_id_d, last, last_d, winner;
  logic [WIDTH-1:0] q_d;
  logic             any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  assign busy = (state != IDLE);

  // State and output registers; pointer resets so requester 0 goes first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ack    <= '0;
      q      <= '0;
      last   <= IDW'(NREQ - 1);
    end else begin
      state  <= state_d;
      gnt    <= gnt_d;
      gnt_id <= gnt_id_d;
      ack    <= ack_d;
      q      <= q_d;
      last   <= last_d;
    end
  end

  // Next-state; ack defaults low so it can only pulse for one cycle.
  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    ack_d    = '0;
    q_d      = q;
    last_d   = last;
    case (state)
      IDLE: begin
        if (any) begin
          gnt_d    = NREQ'(onehot(MAX_IDW'(winner)));
          gnt_id_d = winner;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request aborts without rotating the pointer.
        if (req[gnt_id]) begin
          q_d     = wdata[int'(gnt_id)*WIDTH +: WIDTH];
          ack_d   = NREQ'(onehot(MAX_IDW'(gnt_id)));
          last_d  = gnt_id;
          state_d = DONE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed table-driven bench for dff_bank_arbiter plus multi-cycle corner sequences.
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
  } vec_t;

  vec_t tbl [19];

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .ack    (ack),
    .q      (q),
    .busy   (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                         input logic [7:0] qq, input logic b);
    chk({tag, " gnt"},  32'(gnt),  32'(g));
    chk({tag, " ack"},  32'(ack),  32'(a));
    chk({tag, " q"},    32'(q),    32'(qq));
    chk({tag, " busy"}, 32'(busy), 32'(b));
  endtask

  // One rising edge, then land on the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 32'h13121110, 4'b0001, 4'b0000, 8'h00, 1'b1};
    tbl[1]  = '{4'b1111, 32'h13121110, 4'b0001, 4'b0001, 8'h10, 1'b1};
    tbl[2]  = '{4'b1111, 32'h13121110, 4'b0000, 4'b0000, 8'h10, 1'b0};
    tbl[3]  = '{4'b1111, 32'h13121110, 4'b0010, 4'b0000, 8'h10, 1'b1};
    tbl[4]  = '{4'b1111, 32'h13121110, 4'b0010, 4'b0010, 8'h11, 1'b1};
    tbl[5]  = '{4'b1111, 32'h13121110, 4'b0000, 4'b0000, 8'h11, 1'b0};
    tbl[6]  = '{4'b1111, 32'h13121110, 4'b0100, 4'b0000, 8'h11, 1'b1};
    tbl[7]  = '{4'b1111, 32'h13121110, 4'b0100, 4'b0100, 8'h12, 1'b1};
    tbl[8]  = '{4'b1111, 32'h13121110, 4'b0000, 4'b0000, 8'h12, 1'b0};
    tbl[9]  = '{4'b1111, 32'h13121110, 4'b1000, 4'b0000, 8'h12, 1'b1};
    tbl[10] = '{4'b1111, 32'h13121110, 4'b1000, 4'b1000, 8'h13, 1'b1};
    tbl[11] = '{4'b1111, 32'h13121110, 4'b0000, 4'b0000, 8'h13, 1'b0};
    tbl[12] = '{4'b1111, 32'h13121110, 4'b0001, 4'b0000, 8'h13, 1'b1};
    tbl[13] = '{4'b1111, 32'h13121110, 4'b0001, 4'b0001, 8'h10, 1'b1};
    tbl[14] = '{4'b0000, 32'h13121110, 4'b0000, 4'b0000, 8'h10, 1'b0};
    tbl[15] = '{4'b0100, 32'h00A50000, 4'b0100, 4'b0000, 8'h10, 1'b1};
    tbl[16] = '{4'b0100, 32'h00A50000, 4'b0100, 4'b0100, 8'hA5, 1'b1};
    tbl[17] = '{4'b0000, 32'hFFFFFFFF, 4'b0000, 4'b0000, 8'hA5, 1'b0};
    tbl[18] = '{4'b0000, 32'h5A5A5A5A, 4'b0000, 4'b0000, 8'hA5, 1'b0};

    reset = 1'b0;
    req   = '0;
    wdata = '0;
    @(negedge clk);

    // Reset hold with random activity on the inputs.
    for (int i = 0; i < 5; i++) begin
      req   = 4'($urandom);
      wdata = $urandom;
      cyc();
      chk_out($sformatf("rst_hold%0d", i), 4'b0000, 4'b0000, 8'h00, 1'b0);
    end
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    cyc();
    chk_out("rst_release", 4'b0000, 4'b0000, 8'h00, 1'b0);

    // All requesting, then single requester 2.
    for (int i = 0; i < 19; i++) begin
      req   = tbl[i].req;
      wdata = tbl[i].wdata;
      cyc();
      chk_out($sformatf("row%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].q, tbl[i].busy);
    end

    // Withdrawal: move pointer to 0 with a write by requester 0.
    req = 4'b0001; wdata = 32'h77005533;
    cyc(); chk_out("wd_w0_g", 4'b0001, 4'b0000, 8'hA5, 1'b1);
    cyc(); chk_out("wd_w0_a", 4'b0001, 4'b0001, 8'h33, 1'b1);
    req = 4'b0000;
    cyc(); chk_out("wd_w0_i", 4'b0000, 4'b0000, 8'h33, 1'b0);
    req = 4'b1010;
    cyc(); chk_out("wd_g1", 4'b0010, 4'b0000, 8'h33, 1'b1);
    chk("wd_g1 gnt_id", 32'(gnt_id), 32'd1);
    req = 4'b1000;
    cyc(); chk_out("wd_abort1", 4'b0000, 4'b0000, 8'h33, 1'b0);
    cyc(); chk_out("wd_g3", 4'b1000, 4'b0000, 8'h33, 1'b1);
    chk("wd_g3 gnt_id", 32'(gnt_id), 32'd3);
    req = 4'b0011;
    cyc(); chk_out("wd_abort3", 4'b0000, 4'b0000, 8'h33, 1'b0);
    cyc(); chk_out("wd_g1_again", 4'b0010, 4'b0000, 8'h33, 1'b1);
    cyc(); chk_out("wd_w1", 4'b0010, 4'b0010, 8'h55, 1'b1);
    req = 4'b0000;
    cyc(); chk_out("wd_idle", 4'b0000, 4'b0000, 8'h55, 1'b0);

    // Asynchronous reset while in GRANT.
    req = 4'b0100; wdata = 32'h00CC0000;
    cyc(); chk_out("ar_g2", 4'b0100, 4'b0000, 8'h55, 1'b1);
    #3 reset = 1'b0;
    #1 chk_out("ar_async", 4'b0000, 4'b0000, 8'h00, 1'b0);
    chk("ar_async gnt_id", 32'(gnt_id), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_out($sformatf("ar_hold%0d", i), 4'b0000, 4'b0000, 8'h00, 1'b0);
    end
    reset = 1'b1;
    req   = 4'b0101;
    cyc(); chk_out("ar_first", 4'b0001, 4'b0000, 8'h00, 1'b1);
    chk("ar_first gnt_id", 32'(gnt_id), 32'd0);
    req = 4'b0000;
    cyc(); chk_out("ar_abort", 4'b0000, 4'b0000, 8'h00, 1'b0);

    // Late request from 0 during DONE of requester 3.
    req = 4'b1000; wdata = 32'h99000042;
    cyc(); chk_out("lr_g3", 4'b1000, 4'b0000, 8'h00, 1'b1);
    cyc(); chk_out("lr_done3", 4'b1000, 4'b1000, 8'h99, 1'b1);
    req = 4'b0001;
    cyc(); chk_out("lr_idle", 4'b0000, 4'b0000, 8'h99, 1'b0);
    cyc(); chk_out("lr_g0", 4'b0001, 4'b0000, 8'h99, 1'b1);
    cyc(); chk_out("lr_w0", 4'b0001, 4'b0001, 8'h42, 1'b1);
    req = 4'b0000;
    cyc(); chk_out("lr_end", 4'b0000, 4'b0000, 8'h42, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared WIDTH-bit D flip-flop register.
- NREQ requesters compete for write access; exactly one winner per transaction loads its data into the shared register Q.
- The winner receives a one-cycle ack.
- Sits in front of the DFF storage element and is the only block that drives its load.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of the shared register
- IDW, $clog2(NREQ), width of the grant index (localparam, derived)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted, takes effect immediately, released synchronously to clk by upstream)
- req  input  NREQ  per-requester write request, level, held until ack or withdrawn
- wdata  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- gnt_id  output  IDW  binary index of current grant, registered
- ack  output  NREQ  one-hot, one-cycle pulse: write completed for that requester
- q  output  WIDTH  shared register contents
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, q=0, gnt=0, gnt_id=0, ack=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
- FSM states are IDLE, GRANT, DONE.
- IDLE:
  - If |req==0, stay in IDLE.
  - Otherwise pick winner w = first i with req[i]==1, searching from last+1 upward with wrap modulo NREQ.
  - At the edge: gnt<=onehot(w), gnt_id<=w, state<=GRANT.
- GRANT:
  - If req[gnt_id]==1 at the edge: q<=wdata[gnt_id], ack[gnt_id]<=1, last<=gnt_id, state<=DONE.
  - If req[gnt_id]==0 (withdrawn): abort. No write, no ack, last unchanged, gnt<=0, state<=IDLE.
- DONE:
  - ack is high for this cycle only.
  - At the edge: ack<=0, gnt<=0, state<=IDLE.
- Latency, with req sampled at edge E0:
  - gnt valid after E0.
  - q and ack valid after E1.
  - ack and gnt cleared after E2.
  - Next arbitration decision at E3.
  - Peak throughput: one write per 3 cycles.
- Requester protocol:
  - Requester drops req in the cycle it sees ack.
  - A req still high at the next IDLE edge is treated as a new request.
- wdata is sampled only at the GRANT edge; changes at any other time are ignored.
- Requests arriving during GRANT or DONE are not lost; they are evaluated at the next IDLE edge.
- Fairness: after a completed write by requester i, requester i has lowest priority. Aborted grants do not rotate the pointer.
- q holds its value indefinitely between writes and is never cleared except by reset.
- busy = (state != IDLE), decoded from the state register.
- Reset mid-operation: everything returns immediately to reset values. A pending write in GRANT is discarded and q=0.
- Invariants: gnt is 0 or one-hot; ack is 0 or one-hot; ack != 0 only in DONE.

Decomposition:
- Package dff_arb_pkg: state enum (IDLE, GRANT, DONE; 2-bit), default NREQ/WIDTH constants, onehot-from-index function.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: any, winner index.
  - Instantiated once in dff_bank_arbiter.
- The top contains the FSM, pointer, q register and output registers.

Test Plan:
- Reset hold: reset=0 with random req/wdata for 5 cycles -> q=0, gnt=0, ack=0, busy=0 throughout; after release with req=0, all remain 0.
- Single requester: req[2]=1, wdata[2]=8'hA5 at E0 -> gnt=4'b0100 after E0, q=8'hA5 and ack=4'b0100 after E1, ack=0 after E2.
- All requesting: req=4'b1111 held, data i = 8'h10+i -> grants in order 0,1,2,3,0; q sequence 10,11,12,13,10; one ack per 3 cycles.
- Withdrawal: req[1]=1, dropped in GRANT cycle while req[3]=1 -> no ack[1], q unchanged; next grant is 3; a later req[1] is served before 0 (pointer not advanced).
- Async reset mid-write: reset=0 asserted between clock edges while in GRANT -> outputs clear without waiting for clk; no ack pulse appears; first grant after release goes to requester 0.
- Late request: req[0] rises during DONE of requester 3's write -> granted at the next IDLE edge; q=wdata[0] three cycles later. Use a 20-time-unit clock period.
